// File: rtl/text_ram_writer.sv
// Text RAM writer: places producer bytes at the cursor, handles CR/LF cursor moves,
// and only touches the RAM while display_on is low. Define TEXT_CLEAR_EN to enable FF (0x0C) screen clear.
module text_ram_writer #(
  parameter logic [7:0] FILL_CHAR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic       display_on,
  output logic [9:0] ram_addr,
  output logic [7:0] ram_din,
  output logic       ram_we,
  output logic [4:0] cursor_row,
  output logic [4:0] cursor_col,
  output logic       busy
);

  localparam logic [7:0] CharCr = 8'h0D;
  localparam logic [7:0] CharLf = 8'h0A;
`ifdef TEXT_CLEAR_EN
  localparam logic [7:0] CharFf = 8'h0C;

  typedef enum logic [1:0] {IDLE, PUT, CLEAR} state_e;
`else
  typedef enum logic {IDLE, PUT} state_e;
`endif

  state_e     state_q;
  logic [4:0] cursorRow_q, cursorCol_q;
  logic [4:0] cursorRow_d, cursorCol_d;
  logic [7:0] char_q;
  logic [9:0] addr_q;
  logic [7:0] din_q;
  logic       we_q;
`ifdef TEXT_CLEAR_EN
  logic [9:0] clearCnt_q;
`endif
  logic       accept;

  assign char_ready = (state_q == IDLE) && !reset;
  assign busy       = (state_q != IDLE) && !reset;
  assign accept     = char_valid && char_ready;

  assign ram_addr   = addr_q;
  assign ram_din    = din_q;
  assign ram_we     = we_q;
  assign cursor_row = cursorRow_q;
  assign cursor_col = cursorCol_q;

  // Treating {row,col} as one 10-bit position gives column wrap into the next row and full-screen wrap for free.
  always_comb begin
    {cursorRow_d, cursorCol_d} = {cursorRow_q, cursorCol_q} + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cursorRow_q <= '0;
      cursorCol_q <= '0;
      char_q      <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
`ifdef TEXT_CLEAR_EN
      clearCnt_q  <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (char_in == CharCr) begin
              cursorCol_q <= '0;
            end else if (char_in == CharLf) begin
              cursorRow_q <= cursorRow_q + 5'd1;
`ifdef TEXT_CLEAR_EN
            end else if (char_in == CharFf) begin
              clearCnt_q <= '0;
              state_q    <= CLEAR;
`endif
            end else begin
              char_q  <= char_in;
              state_q <= PUT;
            end
          end
        end
        PUT: begin
          if (!display_on) begin
            addr_q      <= {cursorRow_q, cursorCol_q};
            din_q       <= char_q;
            we_q        <= 1'b1;
            cursorRow_q <= cursorRow_d;
            cursorCol_q <= cursorCol_d;
            state_q     <= IDLE;
          end
        end
`ifdef TEXT_CLEAR_EN
        CLEAR: begin
          // Counter holds while the display is scanning, so the sweep simply resumes in blanking.
          if (!display_on) begin
            addr_q     <= clearCnt_q;
            din_q      <= FILL_CHAR;
            we_q       <= 1'b1;
            clearCnt_q <= clearCnt_q + 10'd1;
            if (clearCnt_q == 10'd1023) begin
              cursorRow_q <= '0;
              cursorCol_q <= '0;
              state_q     <= IDLE;
            end
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
